// File: rtl/adc_moving_average_pkg.sv
// Shared types and width defaults for the ADC moving-average path.
// The ADC capture stage uses the same width constants.
package adc_moving_average_pkg;

  localparam int DEFAULT_DATA_W     = 12;
  localparam int DEFAULT_LOG2_DEPTH = 3;

  typedef enum logic {
    FILLING = 1'b0,
    RUNNING = 1'b1
  } ma_state_t;

endpackage

// File: rtl/adc_sample_ring.sv
// Circular sample window with one write port and a write pointer.
// The entry under the pointer is read combinationally: this is the sample about to be evicted.
module adc_sample_ring
  import adc_moving_average_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
  input  logic                  Clock_Muestreo,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  clr_ptr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic [LOG2_DEPTH-1:0] wr_ptr
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_reg;

  // Storage is deliberately not reset: stale entries are masked upstream while filling.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clock_Muestreo) begin
        if (wr_en && (wr_ptr_reg == LOG2_DEPTH'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
    end else if (clr_ptr) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

  assign rd_data = mem[wr_ptr_reg];
  assign wr_ptr  = wr_ptr_reg;

endmodule

// File: rtl/adc_moving_average.sv
// Boxcar average over the last 2^LOG2_DEPTH ADC samples, using a running sum.
// The output updates one cycle after each sample once the window is full.
module adc_moving_average
  import adc_moving_average_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
  input  logic                  Clock_Muestreo,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  input  logic                  clear,
  output logic [DATA_W-1:0]     avg_out,
  output logic                  avg_valid,
  output logic                  window_full,
  output logic [LOG2_DEPTH:0]   sample_count
);

  localparam int ACC_W = DATA_W + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {LOG2_DEPTH{1'b0}}};

  ma_state_t         state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] avg_reg, avg_next;
  logic              avg_valid_reg, avg_valid_next;

  logic                  accept;
  logic [DATA_W-1:0]     ring_rd_data;
  logic [LOG2_DEPTH-1:0] ring_wr_ptr;
  logic [DATA_W-1:0]     old_sample;
  logic [ACC_W-1:0]      acc_updated;
  logic [CNT_W-1:0]      count_inc;

  assign accept = sample_valid && !clear;

  adc_sample_ring #(
    .DATA_W    (DATA_W),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring (
    .Clock_Muestreo(Clock_Muestreo),
    .reset         (reset),
    .wr_en         (accept),
    .clr_ptr       (clear),
    .wr_data       (sample_in),
    .rd_data       (ring_rd_data),
    .wr_ptr        (ring_wr_ptr)
  );

  // While filling, the slot under the pointer holds nothing that belongs to this window.
  assign old_sample  = (state_reg == RUNNING) ? ring_rd_data : '0;
  assign acc_updated = acc_reg + {{LOG2_DEPTH{1'b0}}, sample_in}
                               - {{LOG2_DEPTH{1'b0}}, old_sample};
  assign count_inc   = count_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    avg_next       = avg_reg;
    avg_valid_next = 1'b0;

    if (clear) begin
      state_next = FILLING;
      acc_next   = '0;
      count_next = '0;
    end else if (sample_valid) begin
      acc_next = acc_updated;
      case (state_reg)
        FILLING: begin
          count_next = count_inc;
          if (count_inc == FULL_COUNT) begin
            state_next     = RUNNING;
            avg_next       = acc_updated[ACC_W-1:LOG2_DEPTH];
            avg_valid_next = 1'b1;
          end
        end
        RUNNING: begin
          avg_next       = acc_updated[ACC_W-1:LOG2_DEPTH];
          avg_valid_next = 1'b1;
        end
        default: state_next = FILLING;
      endcase
    end
  end

  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset) begin
      state_reg     <= FILLING;
      acc_reg       <= '0;
      count_reg     <= '0;
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      avg_reg       <= avg_next;
      avg_valid_reg <= avg_valid_next;
    end
  end

  assign avg_out      = avg_reg;
  assign avg_valid    = avg_valid_reg;
  assign window_full  = (state_reg == RUNNING);
  assign sample_count = count_reg;

endmodule

// File: tb/tb_adc_moving_average.sv
// Scoreboard bench for adc_moving_average: stimulus pushes expected averages, a monitor pops them.
module tb_adc_moving_average;

  logic        Clock_Muestreo = 1'b0;
  logic        reset          = 1'b1;
  logic [11:0] sample_in      = '0;
  logic        sample_valid   = 1'b0;
  logic        clear          = 1'b0;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        window_full;
  logic [3:0]  sample_count;

  int total  = 0;
  int passed = 0;
  int expq[$];

  adc_moving_average dut (
    .Clock_Muestreo(Clock_Muestreo),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .clear         (clear),
    .avg_out       (avg_out),
    .avg_valid     (avg_valid),
    .window_full   (window_full),
    .sample_count  (sample_count)
  );

  always #5 Clock_Muestreo = ~Clock_Muestreo;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
      $display("check %s: got %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One strobe per call; inputs change 1 time unit after the rising edge.
  task automatic drive(input int v);
    sample_valid = 1'b1;
    sample_in    = 12'(v);
    @(posedge Clock_Muestreo); #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge Clock_Muestreo); #1;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock_Muestreo);
    #1;
  endtask

  // Monitor: every avg_valid must match the oldest outstanding expectation.
  always @(negedge Clock_Muestreo) begin
    if (!reset && avg_valid) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_avg_valid: got avg_out %0d with nothing expected", avg_out);
      end else begin
        int e;
        e = expq.pop_front();
        chk("avg_out", int'(avg_out), e);
        chk("window_full_with_valid", int'(window_full), 1);
      end
    end
  end

  initial begin
    idle(2);
    chk("reset_avg_out", int'(avg_out), 0);
    chk("reset_avg_valid", int'(avg_valid), 0);
    chk("reset_window_full", int'(window_full), 0);
    chk("reset_sample_count", int'(sample_count), 0);
    reset = 1'b0;
    idle(1);

    // Fill with 100s
    for (int i = 0; i < 7; i++) drive(100);
    chk("fill7_count", int'(sample_count), 7);
    chk("fill7_window_full", int'(window_full), 0);
    expq.push_back(100);
    drive(100);
    chk("fill8_count", int'(sample_count), 8);
    chk("fill8_window_full", int'(window_full), 1);

    // Slide in 900s: sums 1600, 2400, ..., 7200
    for (int k = 0; k < 8; k++) begin
      expq.push_back(200 + 100 * k);
      drive(900);
    end
    chk("wr_ptr_wrapped", int'(dut.u_ring.wr_ptr), 0);
    chk("running_count_holds", int'(sample_count), 8);
    idle(2);

    // Clear, then full scale back-to-back
    do_clear();
    chk("clear_count", int'(sample_count), 0);
    chk("clear_window_full", int'(window_full), 0);
    chk("clear_avg_hold", int'(avg_out), 900);
    for (int i = 0; i < 16; i++) begin
      if (i >= 7) expq.push_back(4095);
      drive(4095);
    end
    chk("acc_peak", int'(dut.acc_reg), 32760);
    idle(2);

    // Truncation: seven 0s and one 7
    do_clear();
    for (int i = 0; i < 7; i++) drive(0);
    expq.push_back(0);
    drive(7);
    chk("trunc_acc", int'(dut.acc_reg), 7);
    idle(2);

    // Clear colliding with a strobe
    do_clear();
    for (int i = 0; i < 5; i++) drive(20);
    chk("pre_collision_count", int'(sample_count), 5);
    clear        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 12'd50;
    @(posedge Clock_Muestreo); #1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    chk("collision_count", int'(sample_count), 0);
    chk("collision_window_full", int'(window_full), 0);
    chk("collision_avg_hold", int'(avg_out), 0);
    chk("collision_avg_valid", int'(avg_valid), 0);
    for (int i = 0; i < 7; i++) drive(10);
    expq.push_back(10);
    drive(10);
    expq.push_back(10);
    drive(10);
    idle(2);

    // Asynchronous reset between edges while running
    #3 reset = 1'b1;
    #1;
    chk("async_reset_avg_out", int'(avg_out), 0);
    chk("async_reset_window_full", int'(window_full), 0);
    chk("async_reset_count", int'(sample_count), 0);
    chk("async_reset_avg_valid", int'(avg_valid), 0);
    @(posedge Clock_Muestreo); #3;
    reset = 1'b0;
    idle(1);
    for (int i = 0; i < 7; i++) drive(1);
    expq.push_back(1);
    drive(1);

    // Bounded drain of the scoreboard
    for (int c = 0; c < 20 && expq.size() != 0; c++) idle(1);
    idle(1);
    chk("scoreboard_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_moving_average.md
# adc_moving_average

Downstream consumer of the serial ADC capture stage: it takes each 12-bit sample with its one-cycle `done` strobe. It keeps a circular window of the last 2^LOG2_DEPTH samples and a running sum over that window. Once the window has filled, it outputs a registered boxcar average for every new sample. The block sits between the ADC protocol engine and the display/processing logic, in the same `Clock_Muestreo` domain.

## Interface
- `DATA_W`, 12: sample width; must match the ADC result width.
- `LOG2_DEPTH`, 3: log2 of the window depth (default 8 samples); legal range 1..6.
- `Clock_Muestreo`  in  1  sampling clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `sample_in`  in  DATA_W  sample from the ADC stage; valid only while `sample_valid` = 1.
- `sample_valid`  in  1  one-cycle strobe, connected to the ADC stage's `done`; may be high on consecutive cycles.
- `clear`  in  1  synchronous flush of the window, sum and count.
- `avg_out`  out  DATA_W  registered window average; holds its value between updates.
- `avg_valid`  out  1  one-cycle pulse when `avg_out` updates.
- `window_full`  out  1  high while the FSM is in RUNNING.
- `sample_count`  out  LOG2_DEPTH+1  number of samples in the window, saturating at 2^LOG2_DEPTH.

## Operation
- FSM states:
  - FILLING (reset state).
  - RUNNING.
- Storage:
  - Window buffer of 2^LOG2_DEPTH × DATA_W entries.
  - Write pointer `wr_ptr` of LOG2_DEPTH bits; it wraps modulo the depth.
  - Running sum `acc` of DATA_W+LOG2_DEPTH bits, unsigned. It cannot overflow: the maximum is 4095×8 = 32760 < 2^15.
- On `sample_valid` = 1 and `clear` = 0:
  - Read `old` = buffer[wr_ptr]; force it to 0 while in FILLING.
  - Write buffer[wr_ptr] ← `sample_in`, then increment `wr_ptr`.
  - `acc` ← `acc` + `sample_in` − `old`.
  - In FILLING: increment `sample_count`. When the new count equals 2^LOG2_DEPTH, go to RUNNING.
  - In RUNNING: `sample_count` holds.
- Average computation: `avg_out` ← (new `acc`) >> LOG2_DEPTH, i.e. truncation with no rounding.
  - Updated, with `avg_valid` pulsing, only on samples that leave the FSM in RUNNING. That includes the sample that completes the fill.
  - FILLING samples never pulse `avg_valid`.
- On `clear` = 1:
  - `acc`, `wr_ptr` and `sample_count` go to 0; FSM → FILLING.
  - `avg_out` holds its last value; `avg_valid` = 0.
  - `clear` wins over a simultaneous `sample_valid`, and that sample is discarded.
- Buffer contents are never cleared and need no reset. The FILLING-state zero-forcing of `old` makes stale entries harmless.
- `sample_in` is ignored whenever `sample_valid` = 0.

## Timing
- Reset values: `avg_out` = 0, `avg_valid` = 0, `window_full` = 0, `sample_count` = 0; internally `acc` = 0, `wr_ptr` = 0, FSM = FILLING.
- Latency: `avg_valid` and the new `avg_out` appear one `Clock_Muestreo` cycle after the `sample_valid` cycle.
- `window_full` rises in the same cycle as the first `avg_valid`.
- Throughput: one sample per cycle. Back-to-back `sample_valid` produces back-to-back `avg_valid`.
- Read-before-write at the same `wr_ptr` within one cycle: `old` is the value stored before this cycle's write.
- Wrap-around: after `wr_ptr` = 2^LOG2_DEPTH−1 comes 0, with no bubble.
- Reset asserted mid-operation returns every output to its reset value immediately, regardless of the clock.
- The first sample accepted after reset or clear lands at buffer[0].

## Structure
- Shared package:
  - FSM state encoding: FILLING = 1'b0, RUNNING = 1'b1.
  - Default `DATA_W` and `LOG2_DEPTH` constants, shared with the ADC stage so that widths stay consistent.
- Sub-module `adc_sample_ring`:
  - Holds the buffer array plus `wr_ptr`.
  - Single write port; combinational read of the entry at `wr_ptr`; pointer increment and wrap.
- The top level holds the FSM, `acc`, `sample_count` and the output registers.

## Test plan
- Fill: reset, then 8 strobes of `sample_in` = 100 → no `avg_valid` for samples 1–7; one cycle after sample 8, `avg_valid` = 1, `avg_out` = 100, `window_full` = 1, `sample_count` = 8.
- Slide: continuing, one sample of 900 → sum 7×100 + 900 = 1600, so `avg_out` = 200. Then a further 7 strobes of 900 (8 in total) → `avg_out` = 900 and `wr_ptr` has wrapped back to 0.
- Full scale and back-to-back: 16 consecutive-cycle strobes of 4095 → `avg_valid` on 9 consecutive cycles, each with `avg_out` = 4095; `acc` peaks at 32760 with no overflow.
- Truncation: fill with seven 0 samples and one 7 → sum 7, `avg_out` = 0 (7 >> 3).
- Clear collision: after 5 samples, assert `clear` together with `sample_valid` (`sample_in` = 50) → `sample_count` = 0, `window_full` = 0, `avg_out` unchanged, sample dropped. The next 8 samples of 10 → `avg_out` = 10.
- Reset mid-run: in RUNNING, assert `reset` asynchronously between clock edges → all outputs go to 0 at once. After release, 8 samples of 1 → `avg_out` = 1 on the 8th sample's following cycle.
